// File: rtl/systolic_feeder.sv
// Skews activation vectors onto the rows of a systolic array.
// Row i sees each accepted vector i+1 cycles after its accept.
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   in_valid         upstream vector valid
//   in_ready         feeder can accept (from state only)
//   in_a             activation vector, lane i = in_a[i*DW +: DW]
//   in_last          marks the final vector of a pass (on accept)
//   out_a            skewed activations, lane i to PE row i
//   out_f            per-row fire strobe
//   done             one-cycle pulse, final vector on row LANES-1
//   busy             state is not IDLE
//   vec_count        vectors accepted in current/most recent pass

module systolic_feeder #(
   parameter int LANES = 4,
   parameter int DW    = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [LANES*DW-1:0] in_a,
   input  logic                in_last,
   output logic [LANES*DW-1:0] out_a,
   output logic [LANES-1:0]    out_f,
   output logic                done,
   output logic                busy,
   output logic [15:0]         vec_count
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } state_t;

   state_t state_q;
   state_t state_d;
   logic   acc;

   // Ready depends only on state so upstream never sees a
   // combinational path from its own valid.
   assign in_ready = (state_q != DRAIN);
   assign busy     = (state_q != IDLE);
   assign acc      = in_valid & in_ready;

   // ------------------------------------------------------------
   // State machine
   // ------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE, STREAM: begin
            if (acc) begin
               state_d = in_last ? DRAIN : STREAM;
            end
         end
         DRAIN: begin
            if (done) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------
   // Skew lanes: lane i is a shift register of i+1 stages, each
   // stage holding data plus a fire bit. Non-accept cycles inject
   // fire=0 with zero data, so idle rows never see stale values.
   // ------------------------------------------------------------
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [i:0][DW-1:0] d_q;
      logic [i:0]         f_q;
      logic [DW-1:0]      inj;

      assign inj = acc ? in_a[i*DW +: DW] : '0;

      if (i == 0) begin : g_one
         always_ff @(posedge clk) begin
            if (rst) begin
               d_q <= '0;
               f_q <= '0;
            end else begin
               d_q <= inj;
               f_q <= acc;
            end
         end
      end else begin : g_many
         always_ff @(posedge clk) begin
            if (rst) begin
               d_q <= '0;
               f_q <= '0;
            end else begin
               d_q <= {d_q[i-1:0], inj};
               f_q <= {f_q[i-1:0], acc};
            end
         end
      end

      assign out_a[i*DW +: DW] = d_q[i];
      assign out_f[i]          = f_q[i];
   end

   // ------------------------------------------------------------
   // Last flag rides alongside the deepest lane so done lines up
   // with the final vector reaching the last row.
   // ------------------------------------------------------------
   logic [LANES-1:0] last_q;

   if (LANES == 1) begin : g_last1
      always_ff @(posedge clk) begin
         if (rst) begin
            last_q <= '0;
         end else begin
            last_q <= acc & in_last;
         end
      end
   end else begin : g_lastn
      always_ff @(posedge clk) begin
         if (rst) begin
            last_q <= '0;
         end else begin
            last_q <= {last_q[LANES-2:0], acc & in_last};
         end
      end
   end

   assign done = out_f[LANES-1] & last_q[LANES-1];

   // ------------------------------------------------------------
   // Vector counter: first accept of a pass restarts at 1,
   // later accepts count up and stick at all-ones.
   // ------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         vec_count <= '0;
      end else if (acc) begin
         if (state_q == IDLE) begin
            vec_count <= 16'd1;
         end else if (vec_count != 16'hFFFF) begin
            vec_count <= vec_count + 16'd1;
         end
      end
   end

endmodule
